// File: rtl/ram_access_arbiter_pkg.sv
// Shared widths, FSM state encoding and the round-robin pick for the ram access arbiter.
package ram_access_arbiter_pkg;

    localparam int RAM_ADDR_W = 9;
    localparam int RAM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

    // On a tie the port that did not win last time is picked; otherwise the lone requester.
    function automatic logic pick_port(input logic r0, input logic r1, input logic last_grant);
        if (r0 && r1) begin
            return ~last_grant;
        end
        return r1;
    endfunction

endpackage

// File: rtl/ram_access_arbiter.sv
// Two-port arbiter in front of a single-port ram: serialises accesses, round-robins ties,
// drives the ram strobes for one cycle and returns read data with a one-cycle ack pulse.
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clock_i,
    input  logic              clear_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] ram_d_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_read_o,
    output logic              ram_write_o,
    input  logic [DATA_W-1:0] ram_q_i
);

    arb_state_e        state_q;
    logic              last_grant_q;
    logic              gnt_q;
    logic              we_l_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] ram_d_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_read_q;
    logic              ram_write_q;

    logic              gnt_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    always_comb begin
        gnt_d   = pick_port(req0_i, req1_i, last_grant_q);
        we_d    = gnt_d ? we1_i    : we0_i;
        addr_d  = gnt_d ? addr1_i  : addr0_i;
        wdata_d = gnt_d ? wdata1_i : wdata0_i;
    end

    // Strobes are registered at the grant edge so they are high exactly during ISSUE.
    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_l_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ram_d_q      <= '0;
            ram_addr_q   <= '0;
            ram_read_q   <= 1'b0;
            ram_write_q  <= 1'b0;
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0_i || req1_i) begin
                        gnt_q        <= gnt_d;
                        last_grant_q <= gnt_d;
                        we_l_q       <= we_d;
                        ram_addr_q   <= addr_d;
                        ram_d_q      <= wdata_d;
                        ram_write_q  <= we_d;
                        ram_read_q   <= ~we_d;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    // ram_q_i carries the word addressed during ISSUE in this cycle.
                    if (!we_l_q) begin
                        if (gnt_q) begin
                            rdata1_q <= ram_q_i;
                        end else begin
                            rdata0_q <= ram_q_i;
                        end
                    end
                    ack0_q  <= ~gnt_q;
                    ack1_q  <= gnt_q;
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign ram_d_o     = ram_d_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_read_o  = ram_read_q;
    assign ram_write_o = ram_write_q;

endmodule
